// File: rtl/moving_avg_multi_if.sv
// AXI-Stream style bus carrying NUM_LANES packed samples per beat.
interface moving_avg_multi_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/moving_avg_multi.sv
// Multi-lane rounded moving average, runtime power-of-two length up to 2^MAX_LEN_LOG2.
// Lanes share handshake, write pointer and fill state; each lane owns a history RAM and accumulator.
module moving_avg_multi #(
    parameter  int NUM_LANES    = 2,
    parameter  int WIDTH        = 16,
    parameter  int MAX_LEN_LOG2 = 4,
    localparam int LW           = $clog2(MAX_LEN_LOG2 + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic [LW-1:0]          len_log2,
    moving_avg_multi_if.slave      i_axis,
    moving_avg_multi_if.master     o_axis
);
    localparam int D  = 1 << MAX_LEN_LOG2;
    localparam int PW = MAX_LEN_LOG2;
    localparam int FW = MAX_LEN_LOG2 + 1;
    localparam int AW = WIDTH + MAX_LEN_LOG2 + 1;

    logic [LW-1:0]                       r_len;
    logic [PW-1:0]                       r_wptr;
    logic [FW-1:0]                       r_fill;
    logic                                r_ovalid;
    logic                                r_olast;
    logic [NUM_LANES-1:0][WIDTH-1:0]     r_odata;

    logic [LW-1:0]                       w_len_in;
    logic [FW-1:0]                       w_n;
    logic                                w_full;
    logic [PW-1:0]                       w_raddr;
    logic signed [AW-1:0]                w_half;
    logic                                w_rdy;
    logic                                w_accept;
    logic [NUM_LANES-1:0][WIDTH-1:0]     w_y;

    assign w_len_in = (len_log2 > LW'(MAX_LEN_LOG2)) ? LW'(MAX_LEN_LOG2) : len_log2;
    assign w_n      = FW'(1) << r_len;
    assign w_full   = (r_fill >= w_n);
    // When N equals D the read address equals wptr: the oldest entry is read before being overwritten.
    assign w_raddr  = r_wptr - w_n[PW-1:0];
    assign w_half   = $signed({{(AW-FW){1'b0}}, (w_n >> 1)});

    assign w_rdy        = ~reset & ~clear & (~r_ovalid | o_axis.tready);
    assign w_accept     = i_axis.tvalid & w_rdy;
    assign i_axis.tready = w_rdy;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_len  <= w_len_in;
            r_wptr <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            r_wptr <= r_wptr + PW'(1);
            if (!w_full)
                r_fill <= r_fill + FW'(1);
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0] r_mem [D];
        logic signed [AW-1:0]    r_acc;
        logic signed [WIDTH-1:0] w_x;
        logic signed [WIDTH-1:0] w_d;
        logic signed [AW-1:0]    w_xe;
        logic signed [AW-1:0]    w_de;
        logic signed [AW-1:0]    w_acc_nxt;

        assign w_x       = i_axis.tdata[(NUM_LANES-k)*WIDTH-1 -: WIDTH];
        // Stale RAM after clear is masked by the fill count, so no scrub is needed.
        assign w_d       = w_full ? r_mem[w_raddr] : '0;
        assign w_xe      = {{(AW-WIDTH){w_x[WIDTH-1]}}, w_x};
        assign w_de      = {{(AW-WIDTH){w_d[WIDTH-1]}}, w_d};
        assign w_acc_nxt = r_acc + w_xe - w_de;
        assign w_y[NUM_LANES-1-k] = (r_len == '0) ? w_x
                                  : WIDTH'((w_acc_nxt + w_half) >>> r_len);

        always_ff @(posedge clk) begin
            if (w_accept)
                r_mem[r_wptr] <= w_x;
        end

        always_ff @(posedge clk) begin
            if (reset || clear)
                r_acc <= '0;
            else if (w_accept)
                r_acc <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_ovalid <= 1'b0;
            r_olast  <= 1'b0;
            r_odata  <= '0;
        end else if (w_accept) begin
            r_ovalid <= 1'b1;
            r_olast  <= i_axis.tlast;
            r_odata  <= w_y;
        end else if (o_axis.tready) begin
            r_ovalid <= 1'b0;
        end
    end

    assign o_axis.tdata  = r_odata;
    assign o_axis.tlast  = r_olast;
    assign o_axis.tvalid = r_ovalid;
endmodule

// File: tb/tb_moving_avg_multi.sv
// Directed bench for moving_avg_multi: 2 lanes x 16 bits, max length 16.
module tb_moving_avg_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [2:0] len_log2;
    int         total = 0;
    int         bad   = 0;
    int         t1e [6] = '{25, 50, 75, 100, 100, 100};

    moving_avg_multi_if #(.DATA_W(32)) s_if ();
    moving_avg_multi_if #(.DATA_W(32)) m_if ();

    moving_avg_multi #(.NUM_LANES(2), .WIDTH(16), .MAX_LEN_LOG2(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .len_log2 (len_log2),
        .i_axis   (s_if),
        .o_axis   (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int lane(input int k);
        logic [31:0]       v;
        logic signed [15:0] t;
        v = m_if.tdata;
        t = v[31-16*k -: 16];
        return int'(t);
    endfunction

    function automatic int bp_exp(input int i, input int s);
        int sum = 0;
        for (int j = i - 3; j <= i; j++)
            if (j >= 0) sum += s * j;
        return (sum + 2) >>> 2;
    endfunction

    task automatic put(input int a, input int b, input bit last);
        s_if.tdata  = {16'(a), 16'(b)};
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expo(input string tag, input int e0, input int e1);
        chk({tag, "_v"},  int'(m_if.tvalid), 1);
        chk({tag, "_l0"}, lane(0), e0);
        chk({tag, "_l1"}, lane(1), e1);
    endtask

    task automatic do_clear(input int l);
        s_if.tvalid = 1'b0;
        len_log2    = 3'(l);
        clear       = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int  in_i, out_i, cyc, k;
        bit  acc, stalled;
        logic [31:0] held;

        reset = 1'b1; clear = 1'b0; len_log2 = 3'd2;
        s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld",  int'(m_if.tvalid), 0);
        chk("rst_data", int'(m_if.tdata), 0);
        chk("rst_rdy",  int'(s_if.tready), 0);
        reset = 1'b0;

        // fill and steady state, N=4
        for (int i = 0; i < 6; i++) begin
            put(100, -100, 1'b0);
            expo("fill", t1e[i], -t1e[i]);
        end
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        chk("fill_idle", int'(m_if.tvalid), 0);

        // rounding with negatives, N=2
        s_if.tvalid = 1'b0; len_log2 = 3'd1; clear = 1'b1;
        #1;
        chk("clr_rdy", int'(s_if.tready), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        put(-3, 5, 1'b0); expo("rnd0", -1, 3);
        put(-3, 5, 1'b0); expo("rnd1", -3, 5);
        put(-4, 5, 1'b0); expo("rnd2", -3, 5);
        put( 1, 5, 1'b0); expo("rnd3", -1, 5);
        s_if.tvalid = 1'b0;

        // backpressure with ramp, N=4
        do_clear(2);
        in_i = 0; out_i = 0; cyc = 0;
        s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tvalid = 1'b1;
        m_if.tready = 1'($urandom_range(0, 1));
        while (out_i < 20 && cyc < 400) begin
            #1;
            acc     = s_if.tvalid && s_if.tready;
            stalled = m_if.tvalid && !m_if.tready;
            held    = m_if.tdata;
            if (stalled) chk("bp_rdy", int'(s_if.tready), 0);
            if (m_if.tvalid && m_if.tready) begin
                chk("bp_l0", lane(0), bp_exp(out_i, 1));
                chk("bp_l1", lane(1), bp_exp(out_i, -1));
                out_i++;
            end
            @(posedge clk); #1;
            cyc++;
            if (stalled) begin
                chk("bp_hold_v", int'(m_if.tvalid), 1);
                chk("bp_hold_d", int'(m_if.tdata), int'(held));
            end
            if (acc) begin
                in_i++;
                if (in_i < 20) s_if.tdata = {16'(in_i), 16'(-in_i)};
                else           s_if.tvalid = 1'b0;
            end
            m_if.tready = 1'($urandom_range(0, 1));
        end
        chk("bp_out_cnt", out_i, 20);
        chk("bp_in_cnt",  in_i, 20);
        s_if.tvalid = 1'b0; m_if.tready = 1'b1;
        @(posedge clk); #1;

        // length change without clear is ignored; clear drops the concurrent sample
        do_clear(3);
        put(80, 0, 1'b0); expo("n8a", 10, 0);
        put(80, 0, 1'b0); expo("n8b", 20, 0);
        put(80, 0, 1'b0); expo("n8c", 30, 0);
        len_log2 = 3'd1;
        put(80, 0, 1'b0); expo("n8d", 40, 0);
        clear = 1'b1;
        s_if.tdata = {16'(80), 16'(0)}; s_if.tvalid = 1'b1;
        #1;
        chk("clr_v_rdy", int'(s_if.tready), 0);
        @(posedge clk); #1;
        chk("clr_vld",  int'(m_if.tvalid), 0);
        chk("clr_data", int'(m_if.tdata), 0);
        clear = 1'b0;
        put(80, 0, 1'b0); expo("n2a", 40, 0);
        put(80, 0, 1'b0); expo("n2b", 80, 0);
        s_if.tvalid = 1'b0;

        // lane extremes, N=16, tlast on sample 7
        do_clear(4);
        for (int i = 0; i < 20; i++) begin
            put(32767, -32768, i == 7);
            k = (i + 1 < 16) ? i + 1 : 16;
            expo("ext", (k * 32767 + 8) >>> 4, (k * -32768 + 8) >>> 4);
            chk("ext_last", int'(m_if.tlast), (i == 7) ? 1 : 0);
        end
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;

        // out-of-range length clamps to 16
        do_clear(7);
        put(160, 16, 1'b0); expo("clamp", 10, 1);
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;

        // reset while output is stalled
        m_if.tready = 1'b0;
        put(0, 0, 1'b0);
        chk("stall_vld", int'(m_if.tvalid), 1);
        reset = 1'b1; len_log2 = 3'd2; s_if.tvalid = 1'b0;
        @(posedge clk); #1;
        chk("mrst_vld",  int'(m_if.tvalid), 0);
        chk("mrst_data", int'(m_if.tdata), 0);
        reset = 1'b0; m_if.tready = 1'b1;
        put(100, -100, 1'b0); expo("mrst_first", 25, -25);
        s_if.tvalid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/moving_avg_multi.md
Name: moving_avg_multi

Overview:
- Parametrised successor to the fixed-length complex moving average.
- Averages NUM_LANES independent signed lanes packed in one AXI-Stream word, e.g. I/Q, or I/Q across several antennas.
- Averaging length is runtime-selectable as a power of two up to 2^MAX_LEN_LOG2, with one shared handshake for all lanes.
- Output is rounded. Clear and length changes take effect in a single cycle.
- Sits in RFNoC datapaths ahead of power or correlation detectors.

Parameters:
- NUM_LANES, 2: number of independent signed lanes per word. Lane 0 occupies the MSBs.
- WIDTH, 16: bits per lane, two's complement.
- MAX_LEN_LOG2, 4: log2 of the maximum averaging length. History depth is 2^MAX_LEN_LOG2 per lane.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush: drops state, latches len_log2.
- len_log2  in  ceil(log2(MAX_LEN_LOG2+1))  averaging length N=2^len_log2. Sampled only on reset or clear.
- i_tdata  in  NUM_LANES*WIDTH  input samples. Lane k is at bits [(NUM_LANES-k)*WIDTH-1 -: WIDTH].
- i_tlast  in  1  passed through aligned with its sample.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  NUM_LANES*WIDTH  averaged samples, same lane packing as input.
- o_tlast  out  1  output last.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.

Behaviour:
- Reset (synchronous, active-high):
  - o_tvalid=0, o_tdata=0, o_tlast=0.
  - Accumulators, write pointer and fill counter = 0.
  - len_reg <= len_log2, clamped to MAX_LEN_LOG2 if larger.
- clear: same effect as reset, in one cycle. No RAM scrub.
  - Any sample held in the output register is discarded.
  - If clear coincides with i_tvalid, the input is not accepted: i_tready=0 while clear=1.
- len_log2 changes at any other time are ignored until the next reset or clear.
- Handshake:
  - i_tready = ~reset & ~clear & (~o_tvalid | o_tready).
  - Accept = i_tvalid & i_tready.
  - Output register holds o_tdata/o_tlast stable while o_tvalid & ~o_tready.
  - Full throughput: one sample per cycle with o_tready held high.
- Latency: a sample accepted in cycle k appears on o_tdata with o_tvalid=1 in cycle k+1.
- History storage:
  - Per-lane circular buffer of depth D=2^MAX_LEN_LOG2. Distributed RAM with asynchronous read.
  - Write address wptr; wptr increments modulo D on each accept.
  - Delayed sample d = mem[(wptr - N) mod D] when fill >= N, else d = 0.
  - Stale RAM contents after clear are never used.
- Fill counter: saturates at N, increments on accept while below N.
- Accumulator:
  - Per lane, signed, WIDTH+MAX_LEN_LOG2+1 bits.
  - On accept: acc <= acc + x - d, and mem[wptr] <= x.
- Output per lane:
  - y = (acc_next + (N>>1)) >>> len_reg when len_reg>0; y = x when len_reg=0.
  - Arithmetic shift, round-half-up.
  - Result fits WIDTH bits with no saturation logic required. Truncate to WIDTH.
- Fill behaviour: the first N-1 outputs after reset or clear average against zeros, i.e. y = sum of samples so far / N, rounded. There is no separate warm-up gating.
- o_tlast is the registered i_tlast of the same accepted sample. No packet-boundary reset of the average.
- Lanes are fully independent; only the handshake and control are shared.

Test Plan:
- Fill and steady state: NUM_LANES=1, len_log2=2, constant input 100 × 6 → outputs 25, 50, 75, 100, 100, 100, each 1 cycle after its accept.
- Rounding with negatives: len_log2=1, input -3, -3, -4, +1:
  - sums -3, -6, -7, -3.
  - → outputs -1, -3, -3, -1. Rounding uses +1 before >>>1: (-3+1)>>>1=-1, (-6+1)>>>1=-3, (-7+1)>>>1=-3, (-3+1)>>>1=-1.
- Backpressure: 20-sample ramp 0..19, len_log2=2, o_tready pseudo-random at 50%:
  - Output sequence is identical to the no-stall golden model.
  - o_tdata is stable while stalled.
  - No sample lost or duplicated.
  - i_tready=0 whenever o_tvalid=1 and o_tready=0.
- Clear mid-stream and length change:
  - Run len_log2=3 with value 80, then drive len_log2=1 without clear → averaging stays at N=8.
  - Pulse clear concurrent with i_tvalid → that sample is not accepted and o_tvalid drops the next cycle.
  - Then feed 80 → outputs 40, 80 (N=2, history zeroed).
- Lane independence and extremes: NUM_LANES=2, len_log2=4:
  - Lane 0 at +32767, lane 1 at -32768, 20 samples.
  - → lane 0 ramps to 32767, lane 1 ramps to -32768. No overflow or cross-lane leakage.
  - o_tlast on sample 7 appears only on output 7.
- Reset mid-operation: assert reset for 1 cycle while o_tvalid=1 and o_tready=0 → next cycle o_tvalid=0, o_tdata=0, and the first new sample averages from zero history.
